// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter family: count modes and the
// helper that clamps loads and steps into the legal count range.
package counter_pkg;

    localparam bit CNT_MODE_WRAP = 1'b0;
    localparam bit CNT_MODE_SAT  = 1'b1;

    // Wide enough for any counter instance; callers cast in and out at their own width.
    localparam int CLAMP_W = 64;

    function automatic logic [CLAMP_W-1:0] clamp_to_max(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] max
    );
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_step_alu.sv
// Combinational next-count calculation for one count edge: applies an already
// clamped step up or down and either wraps modulo MAX_VALUE+1 or saturates.
module counter_step_alu
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic             down,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary
);

    // One extra bit so count+step and count+modulus never overflow.
    localparam logic [WIDTH:0] MAX_W = {1'b0, MAX_VALUE};
    localparam logic [WIDTH:0] MOD_W = MAX_W + 1'b1;

    logic [WIDTH:0] cnt_w;
    logic [WIDTH:0] step_w;
    logic [WIDTH:0] sum;

    assign cnt_w  = {1'b0, count};
    assign step_w = {1'b0, step};
    assign sum    = cnt_w + step_w;

    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        if (step_w != '0) begin
            if (!down) begin
                if (mode == CNT_MODE_SAT) begin
                    if (sum >= MAX_W) begin
                        next_count = MAX_VALUE;
                        boundary   = 1'b1;
                    end else begin
                        next_count = WIDTH'(sum);
                    end
                end else if (sum > MAX_W) begin
                    next_count = WIDTH'(sum - MOD_W);
                    boundary   = 1'b1;
                end else begin
                    next_count = WIDTH'(sum);
                end
            end else begin
                if (mode == CNT_MODE_SAT) begin
                    if (step_w >= cnt_w) begin
                        next_count = '0;
                        boundary   = 1'b1;
                    end else begin
                        next_count = WIDTH'(cnt_w - step_w);
                    end
                end else if (step_w > cnt_w) begin
                    next_count = WIDTH'(cnt_w + MOD_W - step_w);
                    boundary   = 1'b1;
                end else begin
                    next_count = WIDTH'(cnt_w - step_w);
                end
            end
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Settable up/down counter with programmable step, modulo limit, wrap or saturate
// mode, synchronous clear, terminal-count pulse and compare-match flag.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
    parameter bit               SATURATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_set_en,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_count_en,
    input  logic             i_down,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_cmp,
    output logic [WIDTH-1:0] number,
    output logic             o_tc,
    output logic             o_zero,
    output logic             o_match
);

    localparam logic MODE = SATURATE ? CNT_MODE_SAT : CNT_MODE_WRAP;

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] data_eff;
    logic [WIDTH-1:0] alu_next;
    logic             alu_tc;

    assign step_eff = WIDTH'(clamp_to_max(CLAMP_W'(i_step), CLAMP_W'(MAX_VALUE)));
    assign data_eff = WIDTH'(clamp_to_max(CLAMP_W'(i_data), CLAMP_W'(MAX_VALUE)));

    counter_step_alu #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE)
    ) u_alu (
        .count      (number),
        .step       (step_eff),
        .down       (i_down),
        .mode       (MODE),
        .next_count (alu_next),
        .boundary   (alu_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            number <= RESET_VALUE;
            o_tc   <= 1'b0;
        end else if (i_clear) begin
            number <= RESET_VALUE;
            o_tc   <= 1'b0;
        end else if (i_set_en) begin
            number <= data_eff;
            o_tc   <= 1'b0;
        end else if (i_count_en) begin
            number <= alu_next;
            o_tc   <= alu_tc;
        end else begin
            o_tc   <= 1'b0;
        end
    end

    assign o_zero  = (number == '0);
    assign o_match = (number == i_cmp);

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the basic settable up-counter.
- Adds up/down direction, programmable step, a modulo limit (MAX_VALUE), wrap or saturate mode, synchronous clear, a terminal-count pulse and a compare-match flag.
- Used as a general event, address and timeout counter across datapath and control blocks; one instance per counted quantity.

Parameters:
- WIDTH, 8, counter and data width in bits (>=2).
- MAX_VALUE, 2**WIDTH-1, highest legal count; the counter range is 0..MAX_VALUE.
- SATURATE, 0, 0 = wrap modulo (MAX_VALUE+1); 1 = clamp at 0 or MAX_VALUE.
- RESET_VALUE, 0, count loaded on reset and clear; must be <= MAX_VALUE.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_clear  input  1  synchronous clear to RESET_VALUE; highest functional priority.
- i_set_en  input  1  load i_data.
- i_data  input  WIDTH  load value.
- i_count_en  input  1  advance the count by i_step.
- i_down  input  1  0 = count up, 1 = count down; sampled only with i_count_en.
- i_step  input  WIDTH  step size; 0 is legal and means hold.
- i_cmp  input  WIDTH  compare value for o_match.
- number  output  WIDTH  current count (registered).
- o_tc  output  1  terminal-count pulse (registered, one cycle).
- o_zero  output  1  number == 0 (combinational from register).
- o_match  output  1  number == i_cmp (combinational).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - number = RESET_VALUE, o_tc = 0.
  - Reset overrides all other inputs, including mid-count.
- Priority per edge: rst_n > i_clear > i_set_en > i_count_en > hold.
- Clear: number <= RESET_VALUE, o_tc <= 0.
- Set:
  - number <= min(i_data, MAX_VALUE), o_tc <= 0.
  - i_count_en is ignored in the same cycle.
- Step clamp: effective step s = min(i_step, MAX_VALUE). All arithmetic uses WIDTH+1 bits so there is no silent overflow.
- Count up, wrap (SATURATE=0):
  - if number + s > MAX_VALUE: number <= number + s - (MAX_VALUE+1), o_tc <= 1
  - else: number <= number + s, o_tc <= 0.
- Count up, saturate:
  - if number + s >= MAX_VALUE and s != 0: number <= MAX_VALUE, o_tc <= 1. This includes the edge that reaches MAX exactly and every further attempt while at MAX.
  - else: number <= number + s, o_tc <= 0.
- Count down, wrap:
  - if s > number: number <= number + (MAX_VALUE+1) - s, o_tc <= 1
  - else: number <= number - s, o_tc <= 0.
- Count down, saturate:
  - if s >= number and s != 0: number <= 0, o_tc <= 1
  - else: number <= number - s, o_tc <= 0.
- s == 0: number is held and o_tc <= 0 in both modes.
- Idle (no enables): number is held, o_tc <= 0. o_tc is therefore a single-cycle pulse unless consecutive count edges each qualify.
- Latency:
  - number and o_tc reflect an operation 1 cycle after the enabling edge.
  - o_zero and o_match follow number (and i_cmp) combinationally with no extra delay.
- i_down, i_step and i_data have no effect unless their enable is active.

Decomposition:
- Package counter_pkg:
  - localparams CNT_MODE_WRAP=0, CNT_MODE_SAT=1.
  - Helper function clamp_to_max(value, max).
- One sub-module, counter_step_alu (purely combinational):
  - Inputs: current count, s, direction, mode.
  - Outputs: next count and the boundary flag.
- The top level holds the register, priority mux and output flags. It is verifiable standalone with exhaustive sweeps at WIDTH=4.

Test Plan:
- Reset/clear: WIDTH=8, RESET_VALUE=5. Reset, then count to 9, then i_clear=1 together with i_set_en=1, i_data=77 -> number=5 and o_tc=0 the next cycle; clear beats set.
- Wrap up with step: MAX_VALUE=9, SATURATE=0, number=7, i_step=4, count up -> number=1, o_tc=1 for exactly one cycle. Next count with step 4 -> number=5, o_tc=0.
- Wrap down: MAX_VALUE=9, number=2, i_down=1, i_step=3 -> number=9, o_tc=1. Repeat with i_step=2 -> number=7, o_tc=0.
- Saturate: SATURATE=1, MAX_VALUE=200, number=198, step 1 up three times -> number 199 (tc 0), 200 (tc 1), 200 (tc 1). Then down with step 250 (clamped to 200) -> number=0, o_tc=1, o_zero=1.
- Set priority and clamp: MAX_VALUE=9, i_set_en=1 with i_count_en=1, i_data=15 -> number=9, o_tc=0. i_cmp=9 -> o_match=1 in the same cycle number becomes 9.
- Reset mid-operation: continuous counting with i_step=1, then rst_n=0 for one edge while i_count_en=1 -> number=RESET_VALUE, o_tc=0. Counting resumes from RESET_VALUE+1 on the first edge after release.
